// File: rtl/sdram_rd_collector_if.sv
// Read-collector stream bundle: session control, SDRAM capture input, FWFT output stream.
// master = read engine / consumer side, slave = collector. SDRAM_RD_OVF_FLAG_EN adds ovf.
interface sdram_rd_collector_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              rd_en;
    logic [DATA_W-1:0] sdram_dq_in;
    logic              data_vld;
    logic              read_trig;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [LVL_W-1:0]  fifo_level;
    logic              busy;
`ifdef SDRAM_RD_OVF_FLAG_EN
    logic              ovf;
`endif

    modport master (
        output rd_en, sdram_dq_in, data_vld, dout_ready,
        input  read_trig, dout, dout_valid, fifo_level, busy
`ifdef SDRAM_RD_OVF_FLAG_EN
        , input ovf
`endif
    );

    modport slave (
        input  rd_en, sdram_dq_in, data_vld, dout_ready,
        output read_trig, dout, dout_valid, fifo_level, busy
`ifdef SDRAM_RD_OVF_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/sdram_rd_collector.sv
// Issues SDRAM read sessions only when a whole session fits, captures data_vld words into a FWFT FIFO.
// Latency: captured word visible on dout one edge later; consumer backpressure via dout_ready.
// Words arriving on a full FIFO without a same-cycle pop are dropped (flagged on ovf with SDRAM_RD_OVF_FLAG_EN).
module sdram_rd_collector #(
    parameter int DATA_W        = 16,
    parameter int DEPTH         = 512,
    parameter int SESSION_WORDS = 256
) (
    input  logic                  sysclk_100M,
    input  logic                  rst,
    sdram_rd_collector_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (SESSION_WORDS > 1) ? $clog2(SESSION_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               pop, push, room;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = (level != '0) & bus.dout_ready;
    assign push = bus.data_vld & ((level != LVL_W'(DEPTH)) | pop);
    assign room = (LVL_W'(DEPTH) - level) >= LVL_W'(SESSION_WORDS);

    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sysclk_100M) begin
        if (push) mem[wr_ptr] <= bus.sdram_dq_in;
    end

    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = (level != '0);
    assign bus.fifo_level = level;

    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    // Stray words outside S_WAIT are captured but never counted toward a session.
    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        bus.read_trig = 1'b0;
        bus.busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (bus.rd_en && room) state_nxt = S_TRIG;
            end
            S_TRIG: begin
                bus.read_trig = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.data_vld) begin
                    if (word_cnt == CNT_W'(SESSION_WORDS - 1)) begin
                        word_cnt_nxt = '0;
                        state_nxt    = S_IDLE;
                    end else begin
                        word_cnt_nxt = word_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SDRAM_RD_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst)                         ovf_q <= 1'b0;
        else if (bus.data_vld && !push)  ovf_q <= 1'b1;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sdram_rd_collector.sv
// Bench for sdram_rd_collector: reference FIFO model with data scoreboard, boundary vector table,
// and hand-written session / reset sequences.
module tb_sdram_rd_collector;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 512;
    localparam int SW     = 256;

    logic sysclk_100M = 1'b0;
    logic rst         = 1'b1;

    always #5 sysclk_100M = ~sysclk_100M;

    sdram_rd_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sdram_rd_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SESSION_WORDS(SW)) dut (
        .sysclk_100M (sysclk_100M),
        .rst         (rst),
        .bus         (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int trig_cnt  = 0;
    int m_level   = 0;
    logic m_ovf   = 1'b0;
    logic [DATA_W-1:0] sb [$];

    typedef struct {
        logic              vld;
        logic [DATA_W-1:0] dq;
        logic              rdy;
        int                exp_level;
        logic              exp_valid;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, settle the pop side against the scoreboard, advance the model.
    task automatic cycle(input logic vld, input logic [DATA_W-1:0] dq, input logic rdy);
        logic pop, push;
        logic [DATA_W-1:0] exp_w;
        bus.data_vld    = vld;
        bus.sdram_dq_in = dq;
        bus.dout_ready  = rdy;
        pop  = rdy && (m_level != 0);
        if (pop) begin
            exp_w = sb.pop_front();
            chk("pop_dout_valid", {31'b0, bus.dout_valid}, 32'd1);
            chk("pop_dout", {16'b0, bus.dout}, {16'b0, exp_w});
        end
        push = vld && ((m_level < DEPTH) || pop);
        if (push) sb.push_back(dq);
        if (vld && !push) m_ovf = 1'b1;
        m_level = m_level + int'(push) - int'(pop);
        @(posedge sysclk_100M);
        #1;
        if (bus.read_trig) trig_cnt++;
    endtask

    task automatic wait_trig(input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            cycle(1'b0, '0, 1'b0);
            n++;
            if (bus.read_trig) seen = 1'b1;
        end
        chk("trig_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (m_level > 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_done", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic got_trig;

        // Full FIFO boundary: simultaneous push/pop, then drop on full, then refill.
        vecs[0] = '{1'b1, 16'hBBBB, 1'b1, 512, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 512, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'hAAAA, 1'b0, 512, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 511, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'hCCCC, 1'b0, 512, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 512, 1'b1, 1'b1};

        bus.rd_en       = 1'b0;
        bus.data_vld    = 1'b0;
        bus.sdram_dq_in = '0;
        bus.dout_ready  = 1'b0;
        repeat (3) @(posedge sysclk_100M);
        #1;
        chk("rst_read_trig", {31'b0, bus.read_trig}, 32'd0);
        chk("rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        chk("rst_level", {22'b0, bus.fifo_level}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
`ifdef SDRAM_RD_OVF_FLAG_EN
        chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
`endif

        // Test 1: first trigger after reset release
        rst       = 1'b0;
        bus.rd_en = 1'b1;
        wait_trig(4, n);
        chk("t1_trig_latency", (n <= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("t1_busy", {31'b0, bus.busy}, 32'd1);
        chk("t1_level", {22'b0, bus.fifo_level}, 32'd0);
        chk("t1_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        cycle(1'b0, '0, 1'b0);
        chk("t1_single_pulse", {31'b0, bus.read_trig}, 32'd0);
        chk("t1_busy_wait", {31'b0, bus.busy}, 32'd1);

        // Test 2: two full sessions fill the FIFO, no third trigger
        for (int i = 0; i < SW; i++) begin
            cycle(1'b1, DATA_W'(i), 1'b0);
            if (i == SW - 2) begin
                chk("t2_busy_before_last", {31'b0, bus.busy}, 32'd1);
                chk("t2_level_255", {22'b0, bus.fifo_level}, 32'd255);
            end
        end
        chk("t2_level_256", {22'b0, bus.fifo_level}, 32'd256);
        chk("t2_busy_done", {31'b0, bus.busy}, 32'd0);
        chk("t2_no_trig_yet", {31'b0, bus.read_trig}, 32'd0);
        cycle(1'b0, '0, 1'b0);
        chk("t2_retrigger", {31'b0, bus.read_trig}, 32'd1);
        cycle(1'b0, '0, 1'b0);
        chk("t2_retrigger_pulse", {31'b0, bus.read_trig}, 32'd0);
        for (int i = 0; i < SW; i++) cycle(1'b1, DATA_W'(i), 1'b0);
        chk("t2_level_512", {22'b0, bus.fifo_level}, 32'd512);
        chk("t2_busy_full", {31'b0, bus.busy}, 32'd0);
        repeat (6) cycle(1'b0, '0, 1'b0);
        chk("t2_no_third_trig", trig_cnt, 32'd2);

        // Tests 4/5: full-FIFO boundary vectors
        foreach (vecs[k]) begin
            cycle(vecs[k].vld, vecs[k].dq, vecs[k].rdy);
            chk($sformatf("vec%0d_level", k), {22'b0, bus.fifo_level}, 32'(vecs[k].exp_level));
            chk($sformatf("vec%0d_valid", k), {31'b0, bus.dout_valid}, {31'b0, vecs[k].exp_valid});
`ifdef SDRAM_RD_OVF_FLAG_EN
            chk($sformatf("vec%0d_ovf", k), {31'b0, bus.ovf}, {31'b0, vecs[k].exp_ovf});
`endif
        end
        chk("vec_no_trig", trig_cnt, 32'd2);

        // Test 3: drain in order; trigger when occupancy drops to a session's worth
        got_trig = 1'b0;
        n = 0;
        while (m_level > 0 && n < 700) begin
            cycle(1'b0, '0, 1'b1);
            n++;
            if (bus.read_trig && !got_trig) begin
                got_trig  = 1'b1;
                bus.rd_en = 1'b0;
                chk("t3_trig_level", {22'b0, bus.fifo_level}, 32'd255);
            end
        end
        chk("t3_trig_fired", {31'b0, got_trig}, 32'd1);
        chk("t3_level_empty", {22'b0, bus.fifo_level}, 32'd0);
        chk("t3_valid_fall", {31'b0, bus.dout_valid}, 32'd0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("t3_empty_pop_ignored", {22'b0, bus.fifo_level}, 32'd0);
        chk("t3_trig_count", trig_cnt, 32'd3);

        // Test 6: reset mid-session discards data and the session
        for (int i = 0; i < 100; i++) cycle(1'b1, DATA_W'(16'h1000 + i), 1'b0);
        chk("t6_level_100", {22'b0, bus.fifo_level}, 32'd100);
        chk("t6_busy_mid", {31'b0, bus.busy}, 32'd1);
        bus.data_vld = 1'b0;
        rst = 1'b1;
        #2;
        chk("t6_rst_level", {22'b0, bus.fifo_level}, 32'd0);
        chk("t6_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("t6_rst_valid", {31'b0, bus.dout_valid}, 32'd0);
        chk("t6_rst_trig", {31'b0, bus.read_trig}, 32'd0);
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
`ifdef SDRAM_RD_OVF_FLAG_EN
        chk("t6_rst_ovf", {31'b0, bus.ovf}, 32'd0);
`endif
        @(posedge sysclk_100M);
        #1;
        rst       = 1'b0;
        bus.rd_en = 1'b1;
        wait_trig(6, n);
        bus.rd_en = 1'b0;
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < SW - 1; i++) cycle(1'b1, DATA_W'(16'h2000 + i), 1'b0);
        chk("t6_busy_255", {31'b0, bus.busy}, 32'd1);
        chk("t6_level_255", {22'b0, bus.fifo_level}, 32'd255);
        cycle(1'b1, DATA_W'(16'h20FF), 1'b0);
        chk("t6_busy_256", {31'b0, bus.busy}, 32'd0);
        chk("t6_level_256", {22'b0, bus.fifo_level}, 32'd256);
        drain(400);
        chk("t6_final_level", {22'b0, bus.fifo_level}, 32'd0);
        chk("t6_final_valid", {31'b0, bus.dout_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
